// File: rtl/mux_writedata_pipe.sv
// mux_writedata_pipe: registered source selector feeding a valid/ready port through a 2-entry skid buffer,
// with default substitution and sticky/counted reporting of out-of-range selectors.
module mux_writedata_pipe #(
    parameter int WIDTH = 32,
    parameter int NUM_INPUTS = 6,
    parameter int SEL_WIDTH = 3,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    input  logic [SEL_WIDTH-1:0]        selector,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            output_final,
    output logic [SEL_WIDTH-1:0]        out_sel,
    output logic                        out_illegal,
    input  logic                        flush,
    input  logic                        err_clear,
    output logic                        err_sticky,
    output logic [CNT_WIDTH-1:0]        illegal_count
);
    localparam int E = WIDTH + SEL_WIDTH + 1;
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
    logic [1:0] state;
    logic [E-1:0] head, skid, entry;
    logic [WIDTH-1:0] srcs [2**SEL_WIDTH];
    logic [2**SEL_WIDTH-1:0] legal;
    logic in_fire, out_fire;
    // Every selector code maps to a table slot; codes past NUM_INPUTS hold the default word.
    for (genvar i = 0; i < 2**SEL_WIDTH; i++) begin : g_src
        if (i < NUM_INPUTS) begin : g_in
            assign srcs[i] = data_in[i*WIDTH +: WIDTH];
            assign legal[i] = 1'b1;
        end else begin : g_def
            assign srcs[i] = DEFAULT_VALUE;
            assign legal[i] = 1'b0;
        end
    end
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign entry = {srcs[selector], selector, ~legal[selector]};
    assign {output_final, out_sel, out_illegal} = head;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head <= '0;
            skid <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state <= ONE;
                    head <= entry;
                end
                ONE: if (in_fire && out_fire) begin
                    head <= entry;
                end else if (in_fire) begin
                    state <= FULL;
                    skid <= entry;
                end else if (out_fire) begin
                    state <= EMPTY;
                end
                FULL: if (out_fire) begin
                    state <= ONE;
                    head <= skid;
                end
                default: state <= EMPTY;
            endcase
        end
    end
    // An illegal accept wins over a simultaneous clear, restarting the count at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
            illegal_count <= '0;
        end else if (in_fire && !legal[selector]) begin
            err_sticky <= 1'b1;
            illegal_count <= err_clear ? CNT_WIDTH'(1) : (&illegal_count ? illegal_count : illegal_count + 1'b1);
        end else if (err_clear) begin
            err_sticky <= 1'b0;
            illegal_count <= '0;
        end
    end
endmodule

// File: tb/tb_mux_writedata_pipe.sv
// tb_mux_writedata_pipe: directed plan scenarios plus random traffic checked against a queue-based model.
module tb_mux_writedata_pipe;
    localparam int W = 32, N = 6, S = 3;
    logic clk = 1'b0, reset = 1'b0;
    logic [N*W-1:0] data_in = '0;
    logic [S-1:0] selector = '0, out_sel, out_sel_s;
    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, err_clear = 1'b0;
    logic in_ready, out_valid, out_illegal, err_sticky;
    logic in_ready_s, out_valid_s, out_illegal_s, err_sticky_s;
    logic [W-1:0] output_final, output_final_s;
    logic [7:0] illegal_count;
    logic [1:0] count_s;
    typedef struct {logic [W-1:0] word; logic [S-1:0] sel; logic ill;} entry_t;
    entry_t q[$];
    bit m_sticky;
    int m_cnt, m_cnt_s, n_tests, n_fail;

    mux_writedata_pipe dut (
        .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .output_final(output_final), .out_sel(out_sel), .out_illegal(out_illegal),
        .flush(flush), .err_clear(err_clear), .err_sticky(err_sticky), .illegal_count(illegal_count)
    );
    mux_writedata_pipe #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .output_final(output_final_s), .out_sel(out_sel_s), .out_illegal(out_illegal_s),
        .flush(flush), .err_clear(err_clear), .err_sticky(err_sticky_s), .illegal_count(count_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky = 0;
        m_cnt = 0;
        m_cnt_s = 0;
    endtask

    // Check the current outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        entry_t e;
        bit fi, fo;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("output_final", output_final, q[0].word);
            chk("out_sel", out_sel, q[0].sel);
            chk("out_illegal", out_illegal, q[0].ill);
        end
        chk("err_sticky", err_sticky, m_sticky);
        chk("illegal_count", illegal_count, m_cnt);
        chk("illegal_count_sat", count_s, m_cnt_s);
        fi = in_valid && q.size() < 2;
        fo = out_ready && q.size() > 0;
        e.sel = selector;
        e.ill = int'(selector) >= N;
        e.word = e.ill ? '0 : data_in[int'(selector)*W +: W];
        @(posedge clk);
        #1;
        if (fi && e.ill) begin
            m_sticky = 1;
            m_cnt = err_clear ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            m_cnt_s = err_clear ? 1 : (m_cnt_s < 3 ? m_cnt_s + 1 : 3);
        end else if (err_clear) begin
            m_sticky = 0;
            m_cnt = 0;
            m_cnt_s = 0;
        end
        if (flush) q.delete();
        else begin
            if (fo) void'(q.pop_front());
            if (fi) q.push_back(e);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_output_final", output_final, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_illegal_count", illegal_count, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        // legal sweep
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = 32'h1000_0000 + i;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            selector = S'(i);
            cycle();
            chk("sweep_word", output_final, 32'h1000_0000 + i);
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        // backpressure
        out_ready = 1'b0;
        data_in[1*W +: W] = 32'hAAAA;
        selector = 3'd1;
        in_valid = 1'b1;
        cycle();
        data_in[2*W +: W] = 32'hBBBB;
        selector = 3'd2;
        cycle();
        in_valid = 1'b0;
        chk("bp_hold", output_final, 32'hAAAA);
        chk("bp_full", in_ready, 0);
        cycle();
        out_ready = 1'b1;
        cycle();
        chk("bp_second", output_final, 32'hBBBB);
        cycle();
        chk("bp_ready_back", in_ready, 1);
        // illegal selects
        in_valid = 1'b1;
        selector = 3'd6;
        cycle();
        selector = 3'd7;
        cycle();
        in_valid = 1'b0;
        chk("ill_word", output_final, 0);
        chk("ill_flag", out_illegal, 1);
        chk("ill_sticky", err_sticky, 1);
        chk("ill_count", illegal_count, 2);
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        chk("clr_count", illegal_count, 0);
        chk("clr_sticky", err_sticky, 0);
        // clear collision
        in_valid = 1'b1;
        err_clear = 1'b1;
        selector = 3'd7;
        cycle();
        err_clear = 1'b0;
        in_valid = 1'b0;
        chk("coll_sticky", err_sticky, 1);
        chk("coll_count", illegal_count, 1);
        // saturation of the 2-bit counter
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        in_valid = 1'b0;
        chk("sat_count", count_s, 3);
        chk("wide_count", illegal_count, 6);
        cycle();
        // flush while FULL
        out_ready = 1'b0;
        in_valid = 1'b1;
        selector = 3'd3;
        cycle();
        selector = 3'd4;
        cycle();
        chk("pre_flush_full", in_ready, 0);
        flush = 1'b1;
        selector = 3'd7;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_count", illegal_count, 6);
        chk("flush_sticky", err_sticky, 1);
        // asynchronous reset while ONE
        in_valid = 1'b1;
        selector = 3'd5;
        cycle();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_output_final", output_final, 0);
        chk("arst_count", illegal_count, 0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
            selector = S'($urandom_range(0, 7));
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 32) == 0;
            err_clear = ($urandom % 24) == 0;
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_writedata_pipe.md
Name: mux_writeData_pipe

Overview:
- Parametrised, registered successor to the register-file write-data selector.
- Selects one of NUM_INPUTS WIDTH-bit sources by index and registers the result.
- Hands the result to the write-back stage through a valid/ready handshake, backed by a 2-entry skid buffer.
- Detects out-of-range selector values, substitutes DEFAULT_VALUE, and reports them through a sticky flag and a saturating counter.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_INPUTS, 6, number of selectable sources (>=2).
- SEL_WIDTH, 3, selector width; must satisfy 2**SEL_WIDTH >= NUM_INPUTS.
- DEFAULT_VALUE, 0, value forwarded when the selector is out of range.
- CNT_WIDTH, 8, width of the illegal-select counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  NUM_INPUTS*WIDTH  flattened sources; source i occupies [i*WIDTH +: WIDTH].
- selector  in  SEL_WIDTH  source index, sampled on in_fire.
- in_valid  in  1  upstream offers selector/data_in.
- in_ready  out  1  block can accept this cycle.
- out_valid  out  1  output_final holds a valid word.
- out_ready  in  1  downstream accepts.
- output_final  out  WIDTH  selected word (head entry).
- out_sel  out  SEL_WIDTH  selector captured with the head entry.
- out_illegal  out  1  head entry came from an out-of-range selector.
- flush  in  1  synchronous discard of all buffered entries.
- err_clear  in  1  clears err_sticky and illegal_count.
- err_sticky  out  1  an illegal selector has been accepted since the last clear.
- illegal_count  out  CNT_WIDTH  saturating count of accepted illegal selectors.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Selection (combinational, sampled on in_fire):
  - selector < NUM_INPUTS: word = data_in slice for that index; illegal = 0.
  - Otherwise: word = DEFAULT_VALUE; illegal = 1.
- Each entry stores {word, selector, illegal}.
- States: EMPTY, ONE (head valid), FULL (head + skid valid).
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - All outputs are driven from registers or state decode only; no combinational path from in_valid/out_ready to any output.
- Transitions:
  - EMPTY: in_fire -> ONE, head <= new entry.
  - ONE:
    - in_fire & !out_fire -> FULL, skid <= new entry.
    - in_fire & out_fire -> ONE, head <= new entry.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL:
    - out_fire -> ONE, head <= skid.
    - No in_fire is possible, since in_ready = 0.
- Latency: 1 cycle from in_fire (when EMPTY) to out_valid. Sustained throughput is 1 word/cycle while out_ready = 1.
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- Holding: output_final/out_sel/out_illegal stay stable while out_valid & !out_ready.
- flush:
  - Next state = EMPTY regardless of in_fire/out_fire in the same cycle; the incoming word is discarded.
  - Does not affect err_sticky or illegal_count.
- Error tracking (counted on in_fire with illegal = 1, including when flush is asserted in the same cycle):
  - err_sticky <= 1.
  - illegal_count increments, saturating at 2**CNT_WIDTH-1.
  - err_clear alone: err_sticky <= 0, illegal_count <= 0.
  - err_clear together with an illegal in_fire: err_sticky = 1, illegal_count = 1.
- Reset (asynchronous assert, removal synchronous to clk):
  - state = EMPTY, so out_valid = 0 and in_ready = 1.
  - output_final = 0, out_sel = 0, out_illegal = 0.
  - err_sticky = 0, illegal_count = 0.
  - Reset mid-transfer discards all entries.

Test Plan:
- Legal sweep: out_ready = 1; selector = 0..5 with data_in[i] = 32'h1000_0000+i, one per cycle -> output_final = 1000_0000..1000_0005 on consecutive cycles, each 1 cycle after accept; out_illegal = 0.
- Backpressure: out_ready = 0; push A = 0xAAAA (sel 1), then B = 0xBBBB (sel 2) -> in_ready drops after B, output_final holds 0xAAAA. Raise out_ready -> 0xAAAA then 0xBBBB; in_ready returns to 1.
- Illegal select: selector = 6, then 7 -> output_final = 0 both times, out_illegal = 1, err_sticky = 1, illegal_count = 2. err_clear -> count 0, sticky 0.
- Clear collision: err_clear in the same cycle as an accepted selector = 7 -> err_sticky = 1, illegal_count = 1.
- Saturation: CNT_WIDTH = 2, five illegal accepts -> illegal_count = 3.
- Flush and reset: FULL state plus flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, error state unchanged. Assert reset while ONE -> out_valid = 0 and output_final = 0 immediately, without a clock edge.
